// File: rtl/stepper_pkg.sv
// Shared types and helpers for the unipolar stepper drive.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_t      - drive controller states (IDLE, RUN, MOVE)
//   PHASE_TABLE  - 8-entry coil pattern table, index 0..7
//   next_index() - next phase index for full/half-step, forward/reverse
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    MOVE = 2'd2
  } state_t;

  // Element [0] is the rightmost entry of the concatenation.
  // Even indices are single-coil states, odd indices are two-coil states.
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001,  // 7
    4'b0001,  // 6
    4'b0011,  // 5
    4'b0010,  // 4
    4'b0110,  // 3
    4'b0100,  // 2
    4'b1100,  // 1
    4'b1000   // 0
  };

  // Half-step walks every entry. Full-step only lands on the odd
  // (two-coil) entries: from an even index it moves a single slot to reach
  // the nearest odd one in the travel direction, otherwise it skips by two.
  // The 3-bit arithmetic provides the mod-8 wrap.
  function automatic logic [2:0] next_index(input logic [2:0] idx,
                                            input logic       half,
                                            input logic       rev);
    logic [2:0] stride;
    stride = (half || !idx[0]) ? 3'd1 : 3'd2;
    return rev ? (idx - stride) : (idx + stride);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every PRESCALE cycles.
// Latency: first tick PRESCALE cycles after clear drops; tick is combinational from the count.
// Backpressure: none; clear holds the count at zero and suppresses tick.
//
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   clear        - synchronous clear, held high while the consumer is idle
//   tick         - one-cycle pulse, high on the last cycle of each period
module tick_prescaler #(
  parameter int PRESCALE = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = !clear && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stepper_drive_ctrl.sv
// Unipolar stepper drive: timed phase advance, counted moves, position count.
// Latency: first step one full interval after entering RUN/MOVE; outputs registered.
// Backpressure: none; move_start is ignored while busy or with motor_en low.
//
// Ports:
//   clk, reset_n    - clock, asynchronous active-low reset
//   motor_en        - 0 forces coils off and the controller idle
//   reverse         - 1 steps the phase index downward
//   half_step       - 1 selects 8-state half-step, 0 two-coil full step
//   continuous      - free-run request when no counted move is active
//   motor_interval  - ticks per step (0 behaves as 1), sampled live
//   move_start      - one-cycle pulse starting a counted move of move_steps
//   busy / done     - counted move in progress / one-cycle completion pulse
//   step_pulse      - one-cycle pulse on every phase advance
//   position        - two's-complement step count, wraps
//   step_drv        - registered coil pattern
module stepper_drive_ctrl
  import stepper_pkg::*;
#(
  parameter int INTERVAL_W = 8,
  parameter int PRESCALE   = 50000,
  parameter int COUNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  motor_en,
  input  logic                  reverse,
  input  logic                  half_step,
  input  logic                  continuous,
  input  logic [INTERVAL_W-1:0] motor_interval,
  input  logic                  move_start,
  input  logic [COUNT_W-1:0]    move_steps,
  output logic                  busy,
  output logic                  done,
  output logic                  step_pulse,
  output logic [COUNT_W-1:0]    position,
  output logic [3:0]            step_drv
);

  state_t                state;
  logic [2:0]            phase_idx;
  logic [2:0]            next_idx;
  logic [COUNT_W-1:0]    remaining;
  logic [INTERVAL_W-1:0] ival_cnt;
  logic [INTERVAL_W-1:0] interval_eff;
  logic [INTERVAL_W:0]   ival_next;

  logic running;
  logic tick;
  logic adv;
  logic go_move;
  logic go_run;
  logic go_idle;
  logic zero_move;
  logic move_fin;
  logic state_entry;
  logic pre_clear;

  // ---------------------------------------------------------------------
  // Transition conditions. Kept as named terms because the same decision
  // both steers the FSM and restarts the step timing on state entry.
  // ---------------------------------------------------------------------
  assign running = (state != IDLE);

  // A move may start from IDLE or RUN; a zero-length move only pulses done.
  assign go_move   = move_start && motor_en && (state != MOVE) && (move_steps != '0);
  assign zero_move = move_start && motor_en && (state != MOVE) && (move_steps == '0);

  // The last advance has already brought remaining to zero; finish now.
  assign move_fin  = (state == MOVE) && motor_en && (remaining == '0);

  assign go_run = ((state == IDLE) && continuous && motor_en && !move_start) ||
                  (move_fin && continuous);

  // In RUN a pending move_start outranks the continuous=0 exit.
  assign go_idle = ((state == RUN)  && (!motor_en || (!continuous && !move_start))) ||
                   ((state == MOVE) && (!motor_en || (move_fin && !continuous)));

  assign state_entry = go_move || go_run || go_idle;
  assign pre_clear   = state_entry || !running;

  // ---------------------------------------------------------------------
  // Step timing: prescaler ticks feed the interval counter.
  // ---------------------------------------------------------------------
  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (pre_clear),
    .tick    (tick)
  );

  assign interval_eff = (motor_interval == '0) ? INTERVAL_W'(1) : motor_interval;
  assign ival_next    = {1'b0, ival_cnt} + (INTERVAL_W + 1)'(1);

  // >= rather than == so that a live reduction of motor_interval below the
  // current count steps on the next tick instead of waiting for a wrap.
  // A finished move (remaining==0) must not take an extra step.
  assign adv = running && motor_en && tick &&
               (ival_next >= {1'b0, interval_eff}) &&
               !((state == MOVE) && (remaining == '0));

  assign next_idx = next_index(phase_idx, half_step, reverse);

  // ---------------------------------------------------------------------
  // Controller FSM with registered busy/done.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (go_move) begin
        state     <= MOVE;
        remaining <= move_steps;
        busy      <= 1'b1;
      end else if (go_run) begin
        state <= RUN;
        busy  <= 1'b0;
        done  <= move_fin;
      end else if (go_idle) begin
        // An abort (motor_en low) leaves move_fin low, so no done pulse.
        state <= IDLE;
        busy  <= 1'b0;
        done  <= move_fin;
      end else begin
        if (zero_move) begin
          done <= 1'b1;
        end
        if (adv && (state == MOVE)) begin
          remaining <= remaining - COUNT_W'(1);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Phase, position and coil drive. step_drv shows the new pattern in the
  // same cycle step_pulse is high; with motor_en low the coils are off but
  // phase_idx is kept so re-enabling restores the holding pattern.
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase_idx  <= 3'd0;
      position   <= '0;
      step_pulse <= 1'b0;
      step_drv   <= 4'b0000;
      ival_cnt   <= '0;
    end else begin
      step_pulse <= adv;

      if (adv) begin
        phase_idx <= next_idx;
        position  <= reverse ? (position - COUNT_W'(1)) : (position + COUNT_W'(1));
      end

      if (!motor_en) begin
        step_drv <= 4'b0000;
      end else begin
        step_drv <= PHASE_TABLE[adv ? next_idx : phase_idx];
      end

      if (pre_clear || adv) begin
        ival_cnt <= '0;
      end else if (tick) begin
        ival_cnt <= ival_cnt + INTERVAL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_stepper_drive_ctrl.sv
// Scoreboard bench for stepper_drive_ctrl with PRESCALE=4.
// Stimulus pushes expected step/done events (cycle, pattern, position, busy);
// a negedge monitor pops and compares whenever step_pulse or done is high.
module tb_stepper_drive_ctrl;

  localparam int INTERVAL_W = 8;
  localparam int PRESCALE   = 4;
  localparam int COUNT_W    = 16;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  motor_en = 1'b0;
  logic                  reverse = 1'b0;
  logic                  half_step = 1'b0;
  logic                  continuous = 1'b0;
  logic [INTERVAL_W-1:0] motor_interval = '0;
  logic                  move_start = 1'b0;
  logic [COUNT_W-1:0]    move_steps = '0;
  logic                  busy;
  logic                  done;
  logic                  step_pulse;
  logic [COUNT_W-1:0]    position;
  logic [3:0]            step_drv;

  stepper_drive_ctrl #(
    .INTERVAL_W (INTERVAL_W),
    .PRESCALE   (PRESCALE),
    .COUNT_W    (COUNT_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .motor_en       (motor_en),
    .reverse        (reverse),
    .half_step      (half_step),
    .continuous     (continuous),
    .motor_interval (motor_interval),
    .move_start     (move_start),
    .move_steps     (move_steps),
    .busy           (busy),
    .done           (done),
    .step_pulse     (step_pulse),
    .position       (position),
    .step_drv       (step_drv)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; read only on falling edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int          cyc;
    logic        is_done;
    logic [3:0]  drv;
    logic [15:0] pos;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Hand-computed pattern sequences.
  logic [3:0] half_fwd [8];
  logic [3:0] full_rev [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input int c, input logic d, input logic [3:0] drv,
                           input int pos, input logic b);
    exp_t e;
    e.cyc     = c;
    e.is_done = d;
    e.drv     = drv;
    e.pos     = 16'(pos);
    e.busy    = b;
    sb.push_back(e);
  endtask

  // Wait (bounded) for all queued events to be observed.
  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout: %0d expected events never seen", name, sb.size());
      sb.delete();
    end
  endtask

  // Monitor: every step or done pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_n && (step_pulse === 1'b1 || done === 1'b1)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: cyc=%0d step_pulse=%b done=%b drv=%b pos=%0d busy=%b",
                 cyc, step_pulse, done, step_drv, $signed(position), busy);
      end else begin
        mon_e = sb.pop_front();
        if (cyc != mon_e.cyc || done !== mon_e.is_done || step_pulse !== !mon_e.is_done ||
            step_drv !== mon_e.drv || position !== mon_e.pos || busy !== mon_e.busy) begin
          errors++;
          $display("FAIL event: got cyc=%0d done=%b pulse=%b drv=%b pos=%0d busy=%b, expected cyc=%0d done=%b drv=%b pos=%0d busy=%b",
                   cyc, done, step_pulse, step_drv, $signed(position), busy,
                   mon_e.cyc, mon_e.is_done, mon_e.drv, $signed(mon_e.pos), mon_e.busy);
        end
      end
    end
  end

  initial begin
    int t0;
    int t1;
    int ta;

    half_fwd = '{4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001, 4'b1000};
    full_rev = '{4'b1001, 4'b0011, 4'b0110, 4'b1100, 4'b1001};

    // ---- Reset values, then half-step continuous run, interval 2 -------
    motor_en = 1'b1; half_step = 1'b1; continuous = 1'b1;
    reverse = 1'b0; motor_interval = 8'd2;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_step_pulse", step_pulse, 1'b0);
    check("reset_position", position, 16'd0);
    check("reset_step_drv", step_drv, 4'b0000);
    reset_n = 1'b1;
    t0 = cyc;
    @(negedge clk);
    check("idle_hold_drv", step_drv, 4'b1000);
    for (int k = 1; k <= 8; k++) expect_ev(t0 + 1 + 8 * k, 1'b0, half_fwd[k-1], k, 1'b0);
    drain("half_run");
    continuous = 1'b0;
    repeat (2) @(negedge clk);

    // ---- Full-step reverse continuous run from index 0 -----------------
    reset_n = 1'b0;
    half_step = 1'b0; reverse = 1'b1; motor_interval = 8'd1; continuous = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    t0 = cyc;
    for (int k = 1; k <= 5; k++) expect_ev(t0 + 1 + 4 * k, 1'b0, full_rev[k-1], -k, 1'b0);
    drain("full_rev_run");
    continuous = 1'b0;
    reverse = 1'b0;
    repeat (2) @(negedge clk);

    // ---- Counted move of 5, second start while busy ignored ------------
    reset_n = 1'b0;
    half_step = 1'b1; motor_interval = 8'd1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    move_start = 1'b1; move_steps = 16'd5;
    t0 = cyc;
    for (int k = 1; k <= 5; k++) expect_ev(t0 + 1 + 4 * k, 1'b0, half_fwd[k-1], k, 1'b1);
    expect_ev(t0 + 22, 1'b1, 4'b0011, 5, 1'b0);
    @(negedge clk);
    move_start = 1'b0;
    check("move_busy_high", busy, 1'b1);
    @(negedge clk);
    move_start = 1'b1; move_steps = 16'd100;
    @(negedge clk);
    move_start = 1'b0;
    drain("move5");

    // ---- Zero-length move ----------------------------------------------
    @(negedge clk);
    move_start = 1'b1; move_steps = 16'd0;
    t1 = cyc;
    expect_ev(t1 + 1, 1'b1, 4'b0011, 5, 1'b0);
    @(negedge clk);
    move_start = 1'b0;
    drain("zero_move");
    repeat (10) @(negedge clk);
    check("zero_move_busy", busy, 1'b0);
    check("zero_move_position", position, 16'd5);

    // ---- Abort after 3 of 10 steps, then re-enable ---------------------
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    move_start = 1'b1; move_steps = 16'd10;
    t0 = cyc;
    for (int k = 1; k <= 3; k++) expect_ev(t0 + 1 + 4 * k, 1'b0, half_fwd[k-1], k, 1'b1);
    @(negedge clk);
    move_start = 1'b0;
    drain("abort_steps");
    motor_en = 1'b0;
    @(negedge clk);
    check("abort_drv_off", step_drv, 4'b0000);
    check("abort_busy", busy, 1'b0);
    check("abort_position", position, 16'd3);
    repeat (20) @(negedge clk);
    motor_en = 1'b1;
    @(negedge clk);
    check("reenable_hold_drv", step_drv, 4'b0110);

    // ---- interval=0 behaves as 1, then async reset mid-move ------------
    reset_n = 1'b0;
    motor_interval = 8'd0; continuous = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    t0 = cyc;
    for (int k = 1; k <= 3; k++) expect_ev(t0 + 1 + 4 * k, 1'b0, half_fwd[k-1], k, 1'b0);
    drain("interval0_run");
    continuous = 1'b0;
    repeat (2) @(negedge clk);
    move_start = 1'b1; move_steps = 16'd10;
    ta = cyc;
    expect_ev(ta + 5, 1'b0, 4'b0010, 4, 1'b1);
    @(negedge clk);
    move_start = 1'b0;
    drain("interval0_move");
    reset_n = 1'b0;
    #1;
    check("midreset_busy", busy, 1'b0);
    check("midreset_done", done, 1'b0);
    check("midreset_step_pulse", step_pulse, 1'b0);
    check("midreset_position", position, 16'd0);
    check("midreset_step_drv", step_drv, 4'b0000);
    repeat (3) @(negedge clk);
    motor_en = 1'b0;
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    drain("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
